pwm_sequencer: RTL and testbench

PWM_SEQUENCER -- requirements
Module: pwm_sequencer

---
 rtl/pwm_sequencer.sv | 123 ++++++++++++
 tb/tb_pwm_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pwm_sequencer.sv
// Sixteen-channel PWM sequencer with a shared duty cycle. Enables and duty are
// shadowed and only take effect at period boundaries, so outputs never glitch mid-period.
module pwm_sequencer #(
    parameter int unsigned DIV = 3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start,
    output logic        running
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [11:0] DIV_LAST = 12'(DIV - 1);

    state_t      state, state_nxt;
    logic [11:0] div_cnt, div_cnt_nxt;
    logic [7:0]  pwm_cnt, pwm_cnt_nxt;
    logic [15:0] act_out, act_out_nxt;
    logic [15:0] act_pwm, act_pwm_nxt;
    logic [7:0]  act_duty, act_duty_nxt;
    logic [15:0] out_nxt;
    logic        period_start_nxt;
    logic        tick;
    logic        pwm_level;
    logic [15:0] en_out_in;
    logic [15:0] en_pwm_in;

    assign en_out_in = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm_in = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign tick      = (div_cnt == DIV_LAST);
    assign running   = (state == RUN);

    always_comb begin
        state_nxt        = state;
        div_cnt_nxt      = div_cnt;
        pwm_cnt_nxt      = pwm_cnt;
        act_out_nxt      = act_out;
        act_pwm_nxt      = act_pwm;
        act_duty_nxt     = act_duty;
        period_start_nxt = 1'b0;

        case (state)
            IDLE: begin
                div_cnt_nxt  = '0;
                pwm_cnt_nxt  = '0;
                act_out_nxt  = '0;
                act_pwm_nxt  = '0;
                act_duty_nxt = '0;
                if (|en_out_in) begin
                    state_nxt        = RUN;
                    act_out_nxt      = en_out_in;
                    act_pwm_nxt      = en_pwm_in;
                    act_duty_nxt     = pwm_duty_cycle;
                    period_start_nxt = 1'b1;
                end
            end
            RUN: begin
                if (tick) begin
                    div_cnt_nxt = '0;
                    pwm_cnt_nxt = pwm_cnt + 8'd1;
                    if (pwm_cnt == 8'hFF) begin
                        period_start_nxt = 1'b1;
                        if (|en_out_in) begin
                            act_out_nxt  = en_out_in;
                            act_pwm_nxt  = en_pwm_in;
                            act_duty_nxt = pwm_duty_cycle;
                        end else begin
                            state_nxt    = IDLE;
                            act_out_nxt  = '0;
                            act_pwm_nxt  = '0;
                            act_duty_nxt = '0;
                        end
                    end
                end else begin
                    div_cnt_nxt = div_cnt + 12'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Full duty must hold high through pwm_cnt == 255, which the compare alone cannot reach.
    always_comb begin
        pwm_level = (act_duty == 8'hFF) ? 1'b1 : (pwm_cnt < act_duty);
        out_nxt   = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            out_nxt[i] = act_out[i] & (act_pwm[i] ? pwm_level : 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            div_cnt      <= '0;
            pwm_cnt      <= '0;
            act_out      <= '0;
            act_pwm      <= '0;
            act_duty     <= '0;
            out          <= '0;
            period_start <= 1'b0;
        end else begin
            state        <= state_nxt;
            div_cnt      <= div_cnt_nxt;
            pwm_cnt      <= pwm_cnt_nxt;
            act_out      <= act_out_nxt;
            act_pwm      <= act_pwm_nxt;
            act_duty     <= act_duty_nxt;
            out          <= out_nxt;
            period_start <= period_start_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_sequencer.sv
// Directed bench for pwm_sequencer with DIV = 4 (1024-cycle periods).
// Inputs are driven and outputs sampled on the falling edge.
module tb_pwm_sequencer;

    logic        clk;
    logic        rst;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        period_start;
    logic        running;

    int passed = 0;
    int total  = 0;

    pwm_sequencer #(.DIV(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (out),
        .period_start    (period_start),
        .running         (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    // Samples 1024 cycles: count of out[0] high, period_start pulses, last pulse index (1-based).
    task automatic run_period(output int high, output int ps, output int ps_idx);
        high   = 0;
        ps     = 0;
        ps_idx = -1;
        for (int k = 1; k <= 1024; k++) begin
            @(negedge clk);
            if (out[0]) high++;
            if (period_start) begin
                ps++;
                ps_idx = k;
            end
        end
    endtask

    initial begin
        int high, ps, ps_idx, bad, seen;

        rst             = 1'b1;
        en_reg_out_7_0  = '0;
        en_reg_out_15_8 = '0;
        en_reg_pwm_7_0  = '0;
        en_reg_pwm_15_8 = '0;
        pwm_duty_cycle  = '0;
        repeat (2) @(negedge clk);
        check("reset_out", 32'(out), 32'h0);
        check("reset_running", 32'(running), 32'h0);
        check("reset_ps", 32'(period_start), 32'h0);

        // Idle with all inputs zero
        rst = 1'b0;
        ps = 0;
        bad = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (period_start) ps++;
            if (out != 16'h0 || running) bad++;
        end
        check("idle_ps_count", 32'(ps), 32'h0);
        check("idle_out_or_running", 32'(bad), 32'h0);

        // Channel 0 PWM at duty 128
        en_reg_out_7_0 = 8'h01;
        en_reg_pwm_7_0 = 8'h01;
        pwm_duty_cycle = 8'd128;
        @(negedge clk);
        check("start_running", 32'(running), 32'h1);
        check("start_ps", 32'(period_start), 32'h1);
        check("start_out", 32'(out), 32'h0);
        run_period(high, ps, ps_idx);
        check("d128_high", 32'(high), 32'd512);
        check("d128_ps_count", 32'(ps), 32'd1);
        check("d128_ps_idx", 32'(ps_idx), 32'd1024);

        // Duty 0 mid-period: current period still at 128
        pwm_duty_cycle = 8'd0;
        run_period(high, ps, ps_idx);
        check("d0_pending_high", 32'(high), 32'd512);
        check("d0_pending_ps_idx", 32'(ps_idx), 32'd1024);
        run_period(high, ps, ps_idx);
        check("d0_high", 32'(high), 32'd0);

        pwm_duty_cycle = 8'd255;
        run_period(high, ps, ps_idx);
        check("d255_pending_high", 32'(high), 32'd0);
        run_period(high, ps, ps_idx);
        check("d255_high", 32'(high), 32'd1024);
        check("d255_running", 32'(running), 32'h1);

        // Upper byte static outputs, entered from reset
        rst             = 1'b1;
        en_reg_out_7_0  = 8'h00;
        en_reg_pwm_7_0  = 8'h00;
        en_reg_out_15_8 = 8'hFF;
        pwm_duty_cycle  = 8'd0;
        @(negedge clk);
        check("rst2_out", 32'(out), 32'h0);
        check("rst2_running", 32'(running), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("hi_start_ps", 32'(period_start), 32'h1);
        check("hi_start_out", 32'(out), 32'h0);
        @(negedge clk);
        check("hi_out", 32'(out), 32'hFF00);
        pwm_duty_cycle = 8'd77;
        bad = 0;
        ps = 0;
        for (int k = 2; k <= 1024; k++) begin
            @(negedge clk);
            if (out != 16'hFF00) bad++;
            if (period_start) ps++;
        end
        check("hi_static_out", 32'(bad), 32'h0);
        check("hi_ps_count", 32'(ps), 32'd1);

        // Clear enables mid-period: hold until wrap, then return to IDLE
        repeat (100) @(negedge clk);
        en_reg_out_15_8 = 8'h00;
        bad = 0;
        seen = -1;
        for (int k = 1; k <= 2000 && seen < 0; k++) begin
            @(negedge clk);
            if (period_start) seen = k;
            else if (out != 16'hFF00) bad++;
        end
        check("drain_ps_idx", 32'(seen), 32'd924);
        check("drain_out_held", 32'(bad), 32'h0);
        check("drain_running", 32'(running), 32'h0);
        @(negedge clk);
        check("drain_out_zero", 32'(out), 32'h0);
        check("drain_ps_low", 32'(period_start), 32'h0);

        // Reset at pwm_cnt == 100 with enables held
        en_reg_out_7_0 = 8'h01;
        en_reg_pwm_7_0 = 8'h01;
        pwm_duty_cycle = 8'd128;
        @(negedge clk);
        check("r29_start_ps", 32'(period_start), 32'h1);
        repeat (400) @(negedge clk);
        check("r29_pre_out", 32'(out), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("r29_rst_out", 32'(out), 32'h0);
        check("r29_rst_ps", 32'(period_start), 32'h0);
        check("r29_rst_running", 32'(running), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("r29_restart_ps", 32'(period_start), 32'h1);
        check("r29_restart_running", 32'(running), 32'h1);
        @(negedge clk);
        check("r29_restart_out", 32'(out), 32'h1);
        check("r29_ps_single", 32'(period_start), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
